addsub_selftest: RTL and testbench

On-chip exhaustive tester for the 1-bit adder/subtractor. It drives all eight {a, b, carry/borrow-in} combinations into the adder/subtractor, one after another, and holds each one for a programmable dwell time. At the end of each dwell it samples the adder's carry/borrow-out and sum/difference and compares them with the expected values for the selected mode. It reports the error count, the first failing vector and a pass/done status, so the lab board can self-check without a simulator.

---
 rtl/addsub_selftest.sv | 130 +++++++++++++
 tb/tb_addsub_selftest.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/addsub_selftest.sv
// Exhaustive on-chip tester for a 1-bit adder/subtractor: walks all eight
// {a, b, cbi} vectors, dwells on each, and scores the adder's outputs.
module addsub_selftest #(
  parameter int unsigned DWELL = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_mode_addsub,
  input  logic       i_mode_halffull,
  output logic       o_a,
  output logic       o_b,
  output logic       o_cbi,
  input  logic       i_cbo,
  input  logic       i_sd,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [3:0] o_err_count,
  output logic       o_fail_valid,
  output logic [2:0] o_first_fail
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  state_t     state, state_nx;
  logic [2:0] vec, vec_nx;
  logic [7:0] cnt, cnt_nx;
  logic [3:0] errs, errs_nx;
  logic       fail_valid, fail_valid_nx;
  logic [2:0] first, first_nx;
  logic       sub, sub_nx;
  logic       full, full_nx;

  logic       a, b, c;
  logic       exp_sd, exp_cbo;
  logic       mismatch;
  logic       last;

  // Reference result for the vector currently on the pins.
  always_comb begin
    a        = vec[2];
    b        = vec[1];
    c        = full & vec[0];
    exp_sd   = a ^ b ^ c;
    exp_cbo  = sub ? ((~a & b) | (~a & c) | (b & c))
                   : (( a & b) | ( a & c) | (b & c));
    mismatch = (i_sd != exp_sd) || (i_cbo != exp_cbo);
    last     = (cnt == LAST);
  end

  always_comb begin
    state_nx      = state;
    vec_nx        = vec;
    cnt_nx        = cnt;
    errs_nx       = errs;
    fail_valid_nx = fail_valid;
    first_nx      = first;
    sub_nx        = sub;
    full_nx       = full;

    case (state)
      IDLE, DONE: begin
        if (i_start) begin
          state_nx      = RUN;
          vec_nx        = '0;
          cnt_nx        = '0;
          errs_nx       = '0;
          fail_valid_nx = 1'b0;
          first_nx      = '0;
          sub_nx        = i_mode_addsub;
          full_nx       = i_mode_halffull;
        end
      end
      RUN: begin
        if (last) begin
          cnt_nx = '0;
          if (mismatch) begin
            errs_nx = errs + 4'd1;
            if (!fail_valid) begin
              fail_valid_nx = 1'b1;
              first_nx      = vec;
            end
          end
          // Vector 7 stays on the pins through DONE.
          if (vec == 3'd7) state_nx = DONE;
          else             vec_nx   = vec + 3'd1;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      vec        <= '0;
      cnt        <= '0;
      errs       <= '0;
      fail_valid <= 1'b0;
      first      <= '0;
      sub        <= 1'b0;
      full       <= 1'b0;
    end else begin
      state      <= state_nx;
      vec        <= vec_nx;
      cnt        <= cnt_nx;
      errs       <= errs_nx;
      fail_valid <= fail_valid_nx;
      first      <= first_nx;
      sub        <= sub_nx;
      full       <= full_nx;
    end
  end

  assign o_a          = vec[2];
  assign o_b          = vec[1];
  assign o_cbi        = vec[0];
  assign o_busy       = (state == RUN);
  assign o_done       = (state == DONE);
  assign o_pass       = (state == DONE) && (errs == '0);
  assign o_err_count  = errs;
  assign o_fail_valid = fail_valid;
  assign o_first_fail = first;

endmodule

// File: tb/tb_addsub_selftest.sv
// Bench for addsub_selftest: behavioural adders (good and faulty) feed two
// tester instances, DWELL=4 for table-driven runs and DWELL=2 for timing.
module tb_addsub_selftest;

  localparam int K_FULL_ADD     = 0;
  localparam int K_HALF_SUB     = 1;
  localparam int K_FULL_SUB_SD0 = 2;
  localparam int K_CBO_AND3     = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, as_a = 1'b0, hf_a = 1'b0;
  logic       a_a, b_a, cbi_a, cbo_a, sd_a;
  logic       busy_a, done_a, pass_a, fv_a;
  logic [3:0] err_a;
  logic [2:0] first_a;
  int         kind_a = K_FULL_ADD;

  logic       start_b = 1'b0, as_b = 1'b0, hf_b = 1'b0;
  logic       a_b, b_b, cbi_b, cbo_b, sd_b;
  logic       busy_b, done_b, pass_b, fv_b;
  logic [3:0] err_b;
  logic [2:0] first_b;
  int         kind_b = K_FULL_ADD;

  function automatic logic [1:0] adder(int kind, logic a, logic b, logic c);
    case (kind)
      K_FULL_ADD:     return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
      K_HALF_SUB:     return {~a & b, a ^ b};
      K_FULL_SUB_SD0: return {(~a & b) | (~a & c) | (b & c), 1'b0};
      K_CBO_AND3:     return {a & b & c, a ^ b ^ c};
      default:        return 2'b00;
    endcase
  endfunction

  assign {cbo_a, sd_a} = adder(kind_a, a_a, b_a, cbi_a);
  assign {cbo_b, sd_b} = adder(kind_b, a_b, b_b, cbi_b);

  addsub_selftest #(.DWELL(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a),
    .i_mode_addsub(as_a), .i_mode_halffull(hf_a),
    .o_a(a_a), .o_b(b_a), .o_cbi(cbi_a), .i_cbo(cbo_a), .i_sd(sd_a),
    .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a),
    .o_err_count(err_a), .o_fail_valid(fv_a), .o_first_fail(first_a)
  );

  addsub_selftest #(.DWELL(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b),
    .i_mode_addsub(as_b), .i_mode_halffull(hf_b),
    .o_a(a_b), .o_b(b_b), .o_cbi(cbi_b), .i_cbo(cbo_b), .i_sd(sd_b),
    .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b),
    .o_err_count(err_b), .o_fail_valid(fv_b), .o_first_fail(first_b)
  );

  typedef struct {
    int         kind;
    logic       addsub;
    logic       halffull;
    logic [3:0] err;
    logic [2:0] first;
    logic       fv;
    logic       pass;
  } row_t;

  row_t tbl [6];
  row_t sb [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_row(row_t r);
    row_t e;
    int   k;
    @(negedge clk);
    kind_a  = r.kind;
    as_a    = r.addsub;
    hf_a    = r.halffull;
    start_a = 1'b1;
    sb.push_back(r);
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    chk("e0_busy", 32'(busy_a), 32'd1);
    chk("e0_done", 32'(done_a), 32'd0);
    chk("e0_vec", 32'({a_a, b_a, cbi_a}), 32'd0);
    chk("e0_err_clear", 32'(err_a), 32'd0);
    chk("e0_fv_clear", 32'(fv_a), 32'd0);
    k = 0;
    while (done_a !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("run_len", 32'(k), 32'd32);
    e = sb.pop_front();
    chk("err_count", 32'(err_a), 32'(e.err));
    chk("first_fail", 32'(first_a), 32'(e.first));
    chk("fail_valid", 32'(fv_a), 32'(e.fv));
    chk("pass", 32'(pass_a), 32'(e.pass));
    chk("done_busy", 32'(busy_a), 32'd0);
    chk("done_vec", 32'({a_a, b_a, cbi_a}), 32'd7);
  endtask

  initial begin
    int k;
    tbl[0] = '{K_FULL_ADD,     1'b0, 1'b1, 4'd0, 3'd0, 1'b0, 1'b1};
    tbl[1] = '{K_HALF_SUB,     1'b1, 1'b0, 4'd0, 3'd0, 1'b0, 1'b1};
    tbl[2] = '{K_HALF_SUB,     1'b0, 1'b0, 4'd4, 3'd2, 1'b1, 1'b0};
    tbl[3] = '{K_FULL_SUB_SD0, 1'b1, 1'b1, 4'd4, 3'd1, 1'b1, 1'b0};
    tbl[4] = '{K_FULL_ADD,     1'b1, 1'b1, 4'd4, 3'd1, 1'b1, 1'b0};
    tbl[5] = '{K_CBO_AND3,     1'b0, 1'b1, 4'd3, 3'd3, 1'b1, 1'b0};

    #2 rst = 1'b1;
    #1;
    chk("rst_vec", 32'({a_a, b_a, cbi_a}), 32'd0);
    chk("rst_flags", 32'({busy_a, done_a, pass_a, fv_a}), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_first", 32'(first_a), 32'd0);
    chk("rst_b_all", 32'({a_b, b_b, cbi_b, busy_b, done_b, pass_b, fv_b, err_b, first_b}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_row(tbl[i]);
    // Restart from DONE with three errors outstanding.
    run_row(tbl[5]);

    // Reset part-way through a failing run.
    @(negedge clk);
    kind_a = K_FULL_SUB_SD0; as_a = 1'b1; hf_a = 1'b1; start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_err", 32'(err_a), 32'd1);
    chk("mid_vec", 32'({a_a, b_a, cbi_a}), 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("abort_vec", 32'({a_a, b_a, cbi_a}), 32'd0);
    chk("abort_flags", 32'({busy_a, done_a, pass_a, fv_a}), 32'd0);
    chk("abort_err", 32'(err_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'({busy_a, done_a}), 32'd0);
    run_row(tbl[0]);

    // DWELL=2 timing, ignored start/mode changes, start held into DONE.
    @(negedge clk);
    kind_b = K_FULL_ADD; as_b = 1'b0; hf_b = 1'b1; start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    for (int j = 0; j < 16; j++) begin
      if (j > 0) @(negedge clk);
      chk("d2_vec", 32'({a_b, b_b, cbi_b}), 32'(j / 2));
      if (j == 5) begin start_b = 1'b1; as_b = 1'b1; hf_b = 1'b0; end
      if (j == 6) start_b = 1'b0;
      if (j == 15) begin start_b = 1'b1; as_b = 1'b0; hf_b = 1'b1; end
    end
    @(negedge clk);
    chk("d2_done", 32'(done_b), 32'd1);
    chk("d2_pass", 32'(pass_b), 32'd1);
    chk("d2_err", 32'(err_b), 32'd0);
    chk("d2_vec_hold", 32'({a_b, b_b, cbi_b}), 32'd7);
    @(negedge clk);
    start_b = 1'b0;
    chk("d2_restart_busy", 32'(busy_b), 32'd1);
    chk("d2_restart_done", 32'(done_b), 32'd0);
    chk("d2_restart_vec", 32'({a_b, b_b, cbi_b}), 32'd0);
    k = 0;
    while (done_b !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("d2_rerun_len", 32'(k), 32'd16);
    chk("d2_rerun_pass", 32'(pass_b), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
